i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- System-clocked I2C target (responder) that oversamples SCL/SDA on `i_clk` and exposes the bus as a byte-wide register-access port.
- Companion to the existing `master`; used where the target must live in the core clock domain rather than be clocked by SCL.
- Supports pointer write, burst write, burst read and repeated START.
- Drives SDA open-drain style through an output-enable; never drives SCL.

Parameters:
- TARGET_ADDR, 7'b1011001, 7-bit address this target acknowledges.
- SYNC_STAGES, 2, flops in each SCL/SDA synchroniser (minimum 2).

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCL frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_scl  in  1  bus SCL (resolved wire level).
- i_sda  in  1  bus SDA (resolved wire level).
- o_sda_oe  out  1  1 = pull SDA low; 0 = release.
- o_wr_valid  out  1  one-cycle write strobe.
- o_wr_addr  out  8  register address for the write.
- o_wr_data  out  8  write data.
- o_rd_addr  out  8  register address being read (current pointer).
- i_rd_data  in  8  read data for `o_rd_addr`, combinational from the register owner.
- o_busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; pointer 0; state IDLE.
  - Synchronisers preset to 1 (idle bus).
- Input conditioning:
  - SCL/SDA pass through SYNC_STAGES flops plus one history flop.
  - Edge/condition detect therefore lags the pins by SYNC_STAGES+1 `i_clk` cycles.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Data bits are sampled on SCL rise.
  - `o_sda_oe` changes only on detected SCL fall, or on START/STOP.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- From any state:
  - START (including repeated START) -> ADDR, bit counter cleared, `o_sda_oe` = 0.
  - STOP -> IDLE, `o_sda_oe` = 0, `o_busy` = 0.
- ADDR:
  - Shift 8 bits MSB first.
  - On the SCL fall after bit 8: if bits[7:1] == TARGET_ADDR, assert `o_sda_oe` and go to ADDR_ACK; otherwise go to IGNORE, which never drives.
  - `o_busy` sets on the match.
- ADDR_ACK:
  - Release on the next SCL fall.
  - R/W = 0 -> PTR.
  - R/W = 1 -> load the shift register from `i_rd_data` at `o_rd_addr` on that same fall, drive bit 7 (`o_sda_oe` = ~bit), go to RDATA.
- PTR:
  - 8 bits into the pointer, then ACK (PTR_ACK), then WDATA.
  - No write strobe for the pointer byte.
- WDATA:
  - After 8 bits, on the SCL fall: pulse `o_wr_valid` for exactly 1 `i_clk` with `o_wr_addr` = pointer and `o_wr_data` = byte, ACK, pointer += 1.
  - WDATA_ACK -> WDATA.
- RDATA:
  - Present the next bit on each SCL fall.
  - After bit 0 is sampled, release on the following fall and go to RDATA_ACK.
- RDATA_ACK:
  - Sample the controller's bit on SCL rise.
  - 0 (ACK): pointer += 1; on the next fall reload from `i_rd_data` and go to RDATA.
  - 1 (NACK): go to IGNORE.
- Pointer arithmetic: 8-bit, wraps 0xFF -> 0x00; `o_rd_addr` always equals the pointer.
- Controller writing past the end: every byte is ACKed; there is no full condition.
- STOP or START mid-byte: the partial byte is discarded and no strobe is issued.
- Reset mid-transfer: SDA is released immediately (async).

Optional Feature:
- Macro: `I2C_TARGET_GENERAL_CALL_EN`.
- Defined:
  - Address byte 0x00 with W is ACKed.
  - The following data byte 0x06 is ACKed and clears the pointer to 0; no `o_wr_valid`.
  - Any other data byte is NACKed, then IGNORE.
  - `o_busy` sets as for a match.
- Undefined: address 0x00 is treated as a mismatch (IGNORE, no ACK).

Test Plan:
- Burst write: START, 0xB2, 0x03, 0xAA, 0x55, STOP -> four ACKs; `o_wr_valid` pulses with (0x03, 0xAA) then (0x04, 0x55); `o_busy` low after STOP.
- Combined read:
  - Stimulus: START, 0xB2, 0x10, repeated START, 0xB3; controller ACKs byte 1, NACKs byte 2; STOP. `i_rd_data` = ~`o_rd_addr`.
  - Response: SDA carries 0xEF then 0xEE; no `o_wr_valid`.
- Address mismatch: START, 0xB4, 0x01, STOP -> `o_sda_oe` stays 0 throughout; no strobes; `o_busy` 0.
- Pointer wrap: write pointer 0xFF, then data 0x11, 0x22 -> strobes at 0xFF then 0x00.
- Reset mid-read: assert `i_rst_n` = 0 while driving a 0 bit -> `o_sda_oe` drops the same cycle; after release the next START with 0xB2 is ACKed normally.
- General call (macro defined): pointer set to 0x40, then START, 0x00, 0x06, STOP -> both ACKed; `o_rd_addr` = 0x00. Macro undefined -> 0x00 not ACKed.

Source files
------------

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//   I2C target (responder) running entirely in the i_clk domain. SCL/SDA are
//   oversampled, START/STOP and SCL edges are detected, and the bus is exposed
//   as a byte-wide register-access port: an 8-bit pointer, a one-cycle write
//   strobe, and a combinational read-data return path.
//   Supports pointer write, burst write, burst read and repeated START.
//   SDA is driven open-drain through o_sda_oe. SCL is never driven.
//
// Optional build macro: I2C_TARGET_GENERAL_CALL_EN
//   When defined, address 0x00+W is ACKed. A following 0x06 is ACKed and
//   clears the pointer. Any other byte is NACKed. When undefined, address
//   0x00 is an ordinary mismatch.
//
// Ports
//   i_clk       system clock (>= 8x SCL)
//   i_rst_n     asynchronous active-low reset
//   i_scl       resolved SCL level
//   i_sda       resolved SDA level
//   o_sda_oe    1 = pull SDA low
//   o_wr_valid  one-cycle write strobe
//   o_wr_addr   write register address
//   o_wr_data   write data
//   o_rd_addr   read register address (always the pointer)
//   i_rd_data   read data for o_rd_addr (combinational from owner)
//   o_busy      high from an address-matched START until STOP
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'b1011001,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy
);

`ifdef I2C_TARGET_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  // Input conditioning
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  // SDA may only change with SCL high for START/STOP; require SCL high on
  // both the old and new sample so an SCL edge is never mistaken for one.
  assign start_det = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

  // Protocol state
  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       gc_q, gc_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      gc_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      gc_q       <= gc_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    gc_d       = gc_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      gc_d    = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
      gc_d     = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          shift_d  = {shift_q[6:0], sda_s};
          bitcnt_d = bitcnt_q + 4'd1;
        end
        S_RDATA: bitcnt_d = bitcnt_q + 4'd1;
        S_RDATA_ACK: begin
          // Advance on ACK so i_rd_data is valid for the reload at the fall.
          if (!sda_s) ptr_d = ptr_q + 8'd1;
          else        state_d = S_IGNORE;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: begin
          if (bitcnt_q == 4'd8) begin
            if (shift_q[7:1] == TARGET_ADDR) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
              state_d = S_ADDR_ACK;
            end else if (GC_EN && shift_q == 8'h00) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = 1'b0;
              gc_d    = 1'b1;
              state_d = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          bitcnt_d = '0;
          if (rw_q) begin
            shift_d = i_rd_data;
            oe_d    = ~i_rd_data[7];
            state_d = S_RDATA;
          end else begin
            oe_d    = 1'b0;
            state_d = S_PTR;
          end
        end
        S_PTR: begin
          if (bitcnt_q == 4'd8) begin
            if (gc_q) begin
              if (shift_q == 8'h06) begin
                ptr_d   = '0;
                oe_d    = 1'b1;
                state_d = S_PTR_ACK;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              ptr_d   = shift_q;
              oe_d    = 1'b1;
              state_d = S_PTR_ACK;
            end
          end
        end
        S_PTR_ACK: begin
          oe_d     = 1'b0;
          bitcnt_d = '0;
          state_d  = gc_q ? S_IGNORE : S_WDATA;
        end
        S_WDATA: begin
          if (bitcnt_q == 4'd8) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_q + 8'd1;
            oe_d       = 1'b1;
            state_d    = S_WDATA_ACK;
          end
        end
        S_WDATA_ACK: begin
          oe_d     = 1'b0;
          bitcnt_d = '0;
          state_d  = S_WDATA;
        end
        S_RDATA: begin
          if (bitcnt_q == 4'd8) begin
            oe_d    = 1'b0;
            state_d = S_RDATA_ACK;
          end else begin
            // shift_q[7] is the bit on the wire; present the next one.
            oe_d    = ~shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        S_RDATA_ACK: begin
          bitcnt_d = '0;
          shift_d  = i_rd_data;
          oe_d     = ~i_rd_data[7];
          state_d  = S_RDATA;
        end
        default: ;
      endcase
    end
  end

  assign o_sda_oe   = oe_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_rd_addr  = ptr_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//   Bit-banged I2C controller driving i2c_target_regs. The register owner
//   returns ~address as read data. A behavioural pointer/strobe model
//   provides expected ACKs, write strobes, read bytes and pointer values.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;
  localparam int Q = 80;  // quarter SCL period (8 i_clk cycles)

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ctrl_scl = 1'b1;
  logic       ctrl_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ptr_m;           // model pointer
  logic [15:0] strobe_q[$];     // observed {addr,data} strobes
  logic [7:0]  wbuf[8];
  bit          oe_seen, busy_seen;

  assign sda_line = ctrl_sda & ~sda_oe;
  assign rd_data  = ~rd_addr;

  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'b1011001), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(ctrl_scl), .i_sda(sda_line),
    .o_sda_oe(sda_oe), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_busy(busy)
  );

  always @(negedge clk) begin
    if (wr_valid) strobe_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  // ---------------- bus primitives ----------------
  task automatic bus_start();
    ctrl_sda = 1'b1; ctrl_scl = 1'b1; #Q;
    ctrl_sda = 1'b0; #Q;
    ctrl_scl = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    ctrl_sda = 1'b1; #Q;
    ctrl_scl = 1'b1; #Q;
    ctrl_sda = 1'b0; #Q;
    ctrl_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0; #Q;
    ctrl_scl = 1'b1; #Q;
    ctrl_sda = 1'b1; #Q;
  endtask

  task automatic bus_bit(input logic b, output logic s);
    ctrl_sda = b; #Q;
    ctrl_scl = 1'b1; #(Q/2);
    s = sda_line; #(Q/2);
    ctrl_scl = 1'b0; #Q;
  endtask

  task automatic bus_wbyte(input logic [7:0] b, output logic ack_n);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack_n);
  endtask

  task automatic bus_rbyte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (sda_oe !== 1'b0) begin $display("FAIL rst_oe: got %b want 0", sda_oe); n_fail++; end
    n_checks++;
    if (wr_valid !== 1'b0) begin $display("FAIL rst_wrv: got %b want 0", wr_valid); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_fail++; end
    n_checks++;
    if (rd_addr !== 8'h00) begin $display("FAIL rst_ptr: got %h want 00", rd_addr); n_fail++; end
    n_checks++;
    if ({wr_addr, wr_data} !== 16'h0000) begin
      $display("FAIL rst_wr: got %h want 0000", {wr_addr, wr_data}); n_fail++;
    end
    n_checks++;
    @(posedge clk); #2 rst_n = 1'b1;
    ptr_m = 8'h00;
    repeat (10) @(negedge clk);
    if ({sda_oe, busy} !== 2'b00) begin $display("FAIL post_rst_idle: got %b want 00", {sda_oe, busy}); n_fail++; end
    n_checks++;
  endtask

  // Pointer write followed by n data bytes from wbuf.
  task automatic test_write(input string name, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] ea;
    strobe_q.delete();
    bus_start();
    bus_wbyte(8'hB2, a);
    if (a !== 1'b0) begin $display("FAIL %s addr_ack: got %b want 0", name, a); n_fail++; end
    n_checks++;
    if (busy !== 1'b1) begin $display("FAIL %s busy: got %b want 1", name, busy); n_fail++; end
    n_checks++;
    bus_wbyte(p, a);
    if (a !== 1'b0) begin $display("FAIL %s ptr_ack: got %b want 0", name, a); n_fail++; end
    n_checks++;
    for (int k = 0; k < n; k++) begin
      bus_wbyte(wbuf[k], a);
      if (a !== 1'b0) begin $display("FAIL %s data_ack[%0d]: got %b want 0", name, k, a); n_fail++; end
      n_checks++;
    end
    bus_stop();
    repeat (8) @(negedge clk);
    if (strobe_q.size() != n) begin
      $display("FAIL %s strobe_count: got %0d want %0d", name, strobe_q.size(), n); n_fail++;
    end
    n_checks++;
    for (int k = 0; k < n && k < strobe_q.size(); k++) begin
      ea = p + k[7:0];
      if (strobe_q[k] !== {ea, wbuf[k]}) begin
        $display("FAIL %s strobe[%0d]: got %h want %h", name, k, strobe_q[k], {ea, wbuf[k]}); n_fail++;
      end
      n_checks++;
    end
    ptr_m = p + n[7:0];
    if (rd_addr !== ptr_m) begin $display("FAIL %s ptr: got %h want %h", name, rd_addr, ptr_m); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL %s busy_after_stop: got %b want 0", name, busy); n_fail++; end
    n_checks++;
  endtask

  // Pointer set, repeated START, read n bytes (last one NACKed).
  task automatic test_read(input string name, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] d, exp;
    strobe_q.delete();
    bus_start();
    bus_wbyte(8'hB2, a);
    bus_wbyte(p, a);
    if (a !== 1'b0) begin $display("FAIL %s ptr_ack: got %b want 0", name, a); n_fail++; end
    n_checks++;
    ptr_m = p;
    bus_rstart();
    bus_wbyte(8'hB3, a);
    if (a !== 1'b0) begin $display("FAIL %s raddr_ack: got %b want 0", name, a); n_fail++; end
    n_checks++;
    for (int k = 0; k < n; k++) begin
      bus_rbyte(k == n - 1, d);
      exp = ~ptr_m;
      if (d !== exp) begin $display("FAIL %s rbyte[%0d]: got %h want %h", name, k, d, exp); n_fail++; end
      n_checks++;
      if (k != n - 1) ptr_m = ptr_m + 8'd1;
    end
    bus_stop();
    repeat (8) @(negedge clk);
    if (strobe_q.size() != 0) begin
      $display("FAIL %s no_strobe: got %0d want 0", name, strobe_q.size()); n_fail++;
    end
    n_checks++;
    if (rd_addr !== ptr_m) begin $display("FAIL %s ptr: got %h want %h", name, rd_addr, ptr_m); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL %s busy_after_stop: got %b want 0", name, busy); n_fail++; end
    n_checks++;
  endtask

  task automatic test_burst_write();
    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    test_write("burst_write", 8'h03, 2);
  endtask

  task automatic test_combined_read();
    test_read("combined_read", 8'h10, 2);
  endtask

  task automatic test_ptr_wrap();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    test_write("ptr_wrap", 8'hFF, 2);
  endtask

  task automatic test_addr_mismatch();
    logic       a;
    logic [7:0] ab;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) ab = 8'hB4;
      else begin
        ab = 8'($urandom);
        while (ab[7:1] == 7'b1011001 || ab == 8'h00) ab = 8'($urandom);
      end
      strobe_q.delete();
      oe_seen = 1'b0; busy_seen = 1'b0;
      bus_start();
      bus_wbyte(ab, a);
      if (a !== 1'b1) begin $display("FAIL mismatch_addr_nack[%h]: got %b want 1", ab, a); n_fail++; end
      n_checks++;
      bus_wbyte(8'h01, a);
      bus_stop();
      repeat (8) @(negedge clk);
      if ({oe_seen, busy_seen} !== 2'b00) begin
        $display("FAIL mismatch_quiet[%h]: got oe/busy %b want 00", ab, {oe_seen, busy_seen}); n_fail++;
      end
      n_checks++;
      if (strobe_q.size() != 0) begin
        $display("FAIL mismatch_strobe[%h]: got %0d want 0", ab, strobe_q.size()); n_fail++;
      end
      n_checks++;
      if (rd_addr !== ptr_m) begin $display("FAIL mismatch_ptr: got %h want %h", rd_addr, ptr_m); n_fail++; end
      n_checks++;
    end
  endtask

  task automatic test_random_write();
    logic [7:0] p;
    int         n;
    for (int r = 0; r < 3; r++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
      test_write("rand_write", p, n);
    end
  endtask

  task automatic test_random_read();
    for (int r = 0; r < 3; r++) test_read("rand_read", 8'($urandom), $urandom_range(1, 3));
  endtask

  task automatic test_general_call();
    logic a;
    test_write("gc_ptr", 8'h40, 0);
    strobe_q.delete();
    oe_seen = 1'b0;
    bus_start();
    bus_wbyte(8'h00, a);
`ifdef I2C_TARGET_GENERAL_CALL_EN
    if (a !== 1'b0) begin $display("FAIL gc_addr_ack: got %b want 0", a); n_fail++; end
    n_checks++;
    if (busy !== 1'b1) begin $display("FAIL gc_busy: got %b want 1", busy); n_fail++; end
    n_checks++;
    bus_wbyte(8'h06, a);
    if (a !== 1'b0) begin $display("FAIL gc_06_ack: got %b want 0", a); n_fail++; end
    n_checks++;
    bus_stop();
    repeat (8) @(negedge clk);
    ptr_m = 8'h00;
    if (rd_addr !== ptr_m) begin $display("FAIL gc_ptr: got %h want %h", rd_addr, ptr_m); n_fail++; end
    n_checks++;
    bus_start();
    bus_wbyte(8'h00, a);
    bus_wbyte(8'h05, a);
    if (a !== 1'b1) begin $display("FAIL gc_other_nack: got %b want 1", a); n_fail++; end
    n_checks++;
    bus_stop();
    repeat (8) @(negedge clk);
`else
    if (a !== 1'b1) begin $display("FAIL gc_addr_nack: got %b want 1", a); n_fail++; end
    n_checks++;
    bus_wbyte(8'h06, a);
    bus_stop();
    repeat (8) @(negedge clk);
    if (oe_seen !== 1'b0) begin $display("FAIL gc_never_drive: got %b want 0", oe_seen); n_fail++; end
    n_checks++;
`endif
    if (strobe_q.size() != 0) begin $display("FAIL gc_no_strobe: got %0d want 0", strobe_q.size()); n_fail++; end
    n_checks++;
    if (rd_addr !== ptr_m) begin $display("FAIL gc_final_ptr: got %h want %h", rd_addr, ptr_m); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid_read();
    logic a;
    test_write("rmr_ptr", 8'h80, 0);  // read data ~0x80: first bit is 0
    bus_start();
    bus_wbyte(8'hB3, a);
    if (a !== 1'b0) begin $display("FAIL rmr_addr_ack: got %b want 0", a); n_fail++; end
    n_checks++;
    #(Q/2);
    if (sda_oe !== 1'b1) begin $display("FAIL rmr_driving: got %b want 1", sda_oe); n_fail++; end
    n_checks++;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    if (sda_oe !== 1'b0) begin $display("FAIL rmr_async_release: got %b want 0", sda_oe); n_fail++; end
    n_checks++;
    ptr_m = 8'h00;
    if ({busy, rd_addr} !== {1'b0, ptr_m}) begin
      $display("FAIL rmr_state: got %h want %h", {busy, rd_addr}, {1'b0, ptr_m}); n_fail++;
    end
    n_checks++;
    ctrl_scl = 1'b1; ctrl_sda = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    wbuf[0] = 8'($urandom);
    test_write("after_reset", 8'($urandom), 1);
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_combined_read();
    test_addr_mismatch();
    test_ptr_wrap();
    test_random_write();
    test_random_read();
    test_general_call();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
